// File: rtl/mips_pipeline_top.sv
// mips_pipeline_top: 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB) with internal memories; ports clk, reset; optional FORWARDING_EN enables bypass paths
module mips_mem #(
    parameter int WORDS = 1024,
    parameter int AW = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [0:WORDS-1];
    assign rdata = mem[addr];
    always_ff @(posedge clk) if (we) mem[addr] <= wdata;
endmodule

module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regfile [0:31];
    assign rd1 = (ra1 == 5'd0) ? 32'd0 : (we && wa == ra1) ? wd : regfile[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : (we && wa == ra2) ? wd : regfile[ra2];
    always_ff @(posedge clk) begin
        if (reset) for (int i = 0; i < 32; i++) regfile[i] <= 32'd0;
        else if (we && wa != 5'd0) regfile[wa] <= wd;
    end
endmodule

module mips_pipeline_top #(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input logic clk,
    input logic reset
);
    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);
    logic [31:0] PC, instrWire, nextPC, NPCValue, pc4_id;
    logic [31:0] instrWireID, instrWireEX, instrWireMEM, instrWireWB;
    logic [31:0] PC_ID, PC_EX, PC_MEM, PC_WB;
    logic        valid_id, valid_ex, valid_mem, valid_wb;
    logic        is_r_type_WB, is_i_type_WB, is_j_type_WB, RegWriteWB, instr_retired;
    logic        dataStall, controlStall, taken, is_br, jr_id;
    logic [31:0] WBData, rd1, rd2, ra, rb, a, b, se, alu, ld_data;
    logic [31:0] rs_val_q, rt_val_q, alu_mem_q, sd_mem_q, alu_wb_q, ld_wb_q;
    logic [4:0]  dst_ex, dst_mem, dst_wb;
    logic [5:0]  op_id, op_ex, op_wb;
    // Destination register of an instruction; 0 means it writes nothing.
    function automatic logic [4:0] dst(input logic [31:0] i);
        if (i[31:26] == 6'h00)
            return (i[5:0] inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2a, 6'h2b}) ? i[15:11] : 5'd0;
        if (i[31:26] == 6'h03) return 5'd31;
        return (i[31:26] inside {[6'h08:6'h0f], 6'h23}) ? i[20:16] : 5'd0;
    endfunction
    // True when instruction i reads register d (never for $0).
    function automatic logic reads(input logic [31:0] i, input logic [4:0] d);
        return d != 5'd0 && ((!(i[31:26] inside {6'h02, 6'h03}) && i[25:21] == d) ||
               (i[31:26] inside {6'h00, 6'h04, 6'h05, 6'h2b} && i[20:16] == d));
    endfunction
    mips_mem #(.WORDS(IMEM_WORDS)) u_imem (
        .clk(clk), .we(1'b0), .addr(PC[IAW+1:2]), .wdata(32'd0), .rdata(instrWire)
    );
    mips_mem #(.WORDS(DMEM_WORDS)) u_dmem (
        .clk(clk), .we(instrWireMEM[31:26] == 6'h2b && !reset), .addr(alu_mem_q[DAW+1:2]),
        .wdata(sd_mem_q), .rdata(ld_data)
    );
    mips_regfile u11 (
        .clk(clk), .reset(reset), .we(RegWriteWB), .ra1(instrWireID[25:21]), .ra2(instrWireID[20:16]),
        .wa(dst_wb), .wd(WBData), .rd1(rd1), .rd2(rd2)
    );
    assign nextPC = PC + 32'd4;
    assign op_id = instrWireID[31:26];
    assign op_ex = instrWireEX[31:26];
    assign op_wb = instrWireWB[31:26];
    assign dst_ex = dst(instrWireEX);
    assign dst_mem = dst(instrWireMEM);
    assign dst_wb = dst(instrWireWB);
    assign jr_id = op_id == 6'h00 && instrWireID[5:0] == 6'h08;
    assign is_br = op_id inside {6'h04, 6'h05} || jr_id;
    assign pc4_id = PC_ID + 32'd4;
    always_comb begin
`ifdef FORWARDING_EN
        ra = (dst_mem != 5'd0 && dst_mem == instrWireID[25:21]) ? alu_mem_q : rd1;
        rb = (dst_mem != 5'd0 && dst_mem == instrWireID[20:16]) ? alu_mem_q : rd2;
        // ID compares can only take an ALU result from MEM; anything younger or a load must wait.
        dataStall = (reads(instrWireID, dst_ex) && (op_ex == 6'h23 || is_br)) ||
                    (reads(instrWireID, dst_mem) && is_br && instrWireMEM[31:26] == 6'h23);
`else
        ra = rd1;
        rb = rd2;
        dataStall = reads(instrWireID, dst_ex) || reads(instrWireID, dst_mem);
`endif
        taken = !dataStall && ((op_id == 6'h04 && ra == rb) || (op_id == 6'h05 && ra != rb) ||
                op_id inside {6'h02, 6'h03} || jr_id);
        NPCValue = op_id inside {6'h02, 6'h03} ? {pc4_id[31:28], instrWireID[25:0], 2'b00} :
                   jr_id ? ra : pc4_id + {{14{instrWireID[15]}}, instrWireID[15:0], 2'b00};
        controlStall = taken;
    end
    always_comb begin
`ifdef FORWARDING_EN
        a = (dst_mem != 5'd0 && dst_mem == instrWireEX[25:21]) ? alu_mem_q :
            (dst_wb != 5'd0 && dst_wb == instrWireEX[25:21]) ? WBData : rs_val_q;
        b = (dst_mem != 5'd0 && dst_mem == instrWireEX[20:16]) ? alu_mem_q :
            (dst_wb != 5'd0 && dst_wb == instrWireEX[20:16]) ? WBData : rt_val_q;
`else
        a = rs_val_q;
        b = rt_val_q;
`endif
        se = {{16{instrWireEX[15]}}, instrWireEX[15:0]};
        case (op_ex)
            6'h00: case (instrWireEX[5:0])
                6'h20, 6'h21: alu = a + b;
                6'h22, 6'h23: alu = a - b;
                6'h24:        alu = a & b;
                6'h25:        alu = a | b;
                6'h26:        alu = a ^ b;
                6'h27:        alu = ~(a | b);
                6'h2a:        alu = {31'd0, $signed(a) < $signed(b)};
                6'h2b:        alu = {31'd0, a < b};
                6'h00:        alu = b << instrWireEX[10:6];
                6'h02:        alu = b >> instrWireEX[10:6];
                6'h03:        alu = $signed(b) >>> instrWireEX[10:6];
                default:      alu = 32'd0;
            endcase
            6'h03:                      alu = PC_EX + 32'd4;
            6'h08, 6'h09, 6'h23, 6'h2b: alu = a + se;
            6'h0a:                      alu = {31'd0, $signed(a) < $signed(se)};
            6'h0b:                      alu = {31'd0, a < se};
            6'h0c:                      alu = a & {16'd0, instrWireEX[15:0]};
            6'h0d:                      alu = a | {16'd0, instrWireEX[15:0]};
            6'h0e:                      alu = a ^ {16'd0, instrWireEX[15:0]};
            6'h0f:                      alu = {instrWireEX[15:0], 16'd0};
            default:                    alu = 32'd0;
        endcase
    end
    assign WBData = (op_wb == 6'h23) ? ld_wb_q : alu_wb_q;
    assign RegWriteWB = dst_wb != 5'd0;
    assign instr_retired = valid_wb && instrWireWB != 32'd0;
    assign is_r_type_WB = instr_retired && op_wb == 6'h00;
    assign is_j_type_WB = instr_retired && op_wb inside {6'h02, 6'h03};
    assign is_i_type_WB = instr_retired && !is_r_type_WB && !is_j_type_WB;
    always_ff @(posedge clk) begin
        if (reset) begin
            PC <= RESET_PC;
            {instrWireID, instrWireEX, instrWireMEM, instrWireWB} <= '0;
            {PC_ID, PC_EX, PC_MEM, PC_WB} <= '0;
            {valid_id, valid_ex, valid_mem, valid_wb} <= '0;
            {rs_val_q, rt_val_q, alu_mem_q, sd_mem_q, alu_wb_q, ld_wb_q} <= '0;
        end else begin
            if (!dataStall) begin
                PC <= taken ? NPCValue : nextPC;
                instrWireID <= taken ? 32'd0 : instrWire;
                PC_ID <= taken ? 32'd0 : PC;
                valid_id <= !taken;
            end
            instrWireEX <= dataStall ? 32'd0 : instrWireID;
            PC_EX <= dataStall ? 32'd0 : PC_ID;
            valid_ex <= valid_id && !dataStall;
            rs_val_q <= ra;
            rt_val_q <= rb;
            instrWireMEM <= instrWireEX;
            PC_MEM <= PC_EX;
            valid_mem <= valid_ex;
            alu_mem_q <= alu;
            sd_mem_q <= b;
            instrWireWB <= instrWireMEM;
            PC_WB <= PC_MEM;
            valid_wb <= valid_mem;
            alu_wb_q <= alu_mem_q;
            ld_wb_q <= ld_data;
        end
    end
endmodule

// File: tb/tb_mips_pipeline_top.sv
// tb_mips_pipeline_top: directed self-checking bench for mips_pipeline_top
module tb_mips_pipeline_top;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] prog [0:31];
    logic [31:0] ret_pcs [$];
    int ds_cnt, cs_cnt;
    logic done, sys_r, sys_rw;
    logic [31:0] sys_instr;

    mips_pipeline_top dut (.clk(clk), .reset(reset));

    always #5 clk = ~clk;

    function automatic logic [31:0] ei(input int op, input int rs, input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction
    function automatic logic [31:0] er(input int rs, input int rt, input int rd, input int sh, input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction
    function automatic logic [31:0] ej(input int op, input int tgt);
        return {op[5:0], tgt[25:0]};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 32; i++) prog[i] = 32'd0;
    endtask

    task automatic run_prog();
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = (i < 32) ? prog[i] : 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ds_cnt = 0;
        cs_cnt = 0;
        done = 1'b0;
        sys_r = 1'b0;
        sys_rw = 1'b1;
        sys_instr = 32'd0;
        ret_pcs.delete();
        for (int c = 0; c < 400 && !done; c++) begin
            if (dut.dataStall) ds_cnt++;
            if (dut.controlStall) cs_cnt++;
            if (dut.instr_retired) begin
                ret_pcs.push_back(dut.PC_WB);
                if (dut.instrWireWB == 32'hC) begin
                    done = 1'b1;
                    sys_instr = dut.instrWireWB;
                    sys_r = dut.is_r_type_WB;
                    sys_rw = dut.RegWriteWB;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = 32'd0;
        for (int i = 1; i < 32; i++) dut.u11.regfile[i] = 32'hDEAD0000 | 32'(i);
        repeat (5) @(negedge clk);
        checks++;
        if (dut.PC !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want %h", dut.PC, 32'h0); end
        checks++;
        if (dut.instrWireWB !== 32'd0 || dut.PC_WB !== 32'd0 || dut.instrWireID !== 32'd0) begin
            errors++; $display("FAIL reset_pipe got id=%h wb=%h pcwb=%h want 0", dut.instrWireID, dut.instrWireWB, dut.PC_WB);
        end
        checks++;
        if (dut.dataStall !== 1'b0 || dut.controlStall !== 1'b0) begin
            errors++; $display("FAIL reset_stalls got %b%b want 00", dut.dataStall, dut.controlStall);
        end
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (dut.PC !== 32'(4 * k)) begin errors++; $display("FAIL nop_pc got %h want %h", dut.PC, 32'(4 * k)); end
            checks++;
            if (dut.instr_retired !== 1'b0) begin errors++; $display("FAIL nop_retired got %b want 0", dut.instr_retired); end
        end
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (dut.u11.regfile[i] !== 32'd0) begin
                errors++; $display("FAIL reset_reg%0d got %h want 0", i, dut.u11.regfile[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_prog();
        prog[0] = ei(8, 0, 1, 5);
        prog[1] = ei(8, 1, 2, 3);
        prog[2] = er(1, 2, 3, 0, 32);
        prog[3] = 32'hC;
        run_prog();
        checks++;
        if (!done) begin errors++; $display("FAIL raw_timeout got done=0 want 1"); end
        checks++;
        if (dut.u11.regfile[1] !== 32'd5) begin errors++; $display("FAIL raw_r1 got %0d want 5", dut.u11.regfile[1]); end
        checks++;
        if (dut.u11.regfile[2] !== 32'd8) begin errors++; $display("FAIL raw_r2 got %0d want 8", dut.u11.regfile[2]); end
        checks++;
        if (dut.u11.regfile[3] !== 32'd13) begin errors++; $display("FAIL raw_r3 got %0d want 13", dut.u11.regfile[3]); end
        checks++;
`ifdef FORWARDING_EN
        if (ds_cnt != 0) begin errors++; $display("FAIL raw_stalls got %0d want 0", ds_cnt); end
`else
        if (ds_cnt == 0) begin errors++; $display("FAIL raw_stalls got %0d want >0", ds_cnt); end
`endif
    endtask

    task automatic test_load_use();
        clear_prog();
        prog[0] = ei(8, 0, 3, 13);
        prog[1] = ei(43, 0, 3, 0);
        prog[2] = ei(35, 0, 4, 0);
        prog[3] = ei(8, 4, 5, 1);
        prog[4] = 32'hC;
        dut.u_dmem.mem[0] = 32'hFFFFFFFF;
        run_prog();
        checks++;
        if (!done) begin errors++; $display("FAIL lu_timeout got done=0 want 1"); end
        checks++;
        if (dut.u_dmem.mem[0] !== 32'd13) begin errors++; $display("FAIL lu_dmem0 got %h want %h", dut.u_dmem.mem[0], 32'd13); end
        checks++;
        if (dut.u11.regfile[4] !== 32'd13) begin errors++; $display("FAIL lu_r4 got %0d want 13", dut.u11.regfile[4]); end
        checks++;
        if (dut.u11.regfile[5] !== 32'd14) begin errors++; $display("FAIL lu_r5 got %0d want 14", dut.u11.regfile[5]); end
        checks++;
`ifdef FORWARDING_EN
        if (ds_cnt != 1) begin errors++; $display("FAIL lu_stalls got %0d want 1", ds_cnt); end
`else
        if (ds_cnt == 0) begin errors++; $display("FAIL lu_stalls got %0d want >0", ds_cnt); end
`endif
    endtask

    task automatic test_branch();
        logic [31:0] got;
        clear_prog();
        prog[0] = ei(4, 0, 0, 2);
        prog[1] = ei(8, 0, 6, 1);
        prog[2] = ei(8, 0, 6, 2);
        prog[3] = ei(8, 0, 7, 7);
        prog[4] = 32'hC;
        run_prog();
        checks++;
        if (!done) begin errors++; $display("FAIL br_timeout got done=0 want 1"); end
        checks++;
        if (dut.u11.regfile[6] !== 32'd0) begin errors++; $display("FAIL br_r6 got %0d want 0", dut.u11.regfile[6]); end
        checks++;
        if (dut.u11.regfile[7] !== 32'd7) begin errors++; $display("FAIL br_r7 got %0d want 7", dut.u11.regfile[7]); end
        checks++;
        if (cs_cnt != 1) begin errors++; $display("FAIL br_ctrl_stall got %0d want 1", cs_cnt); end
        checks++;
        if (ret_pcs.size() != 3) begin errors++; $display("FAIL br_retire_count got %0d want 3", ret_pcs.size()); end
        got = (ret_pcs.size() > 1) ? ret_pcs[1] : 32'hFFFFFFFF;
        checks++;
        if (got !== 32'd12) begin errors++; $display("FAIL br_target_next got %h want %h", got, 32'd12); end
    endtask

    task automatic test_jal_jr();
        logic [31:0] exp_pc [5];
        logic [31:0] got;
        exp_pc = '{32'd0, 32'd64, 32'd68, 32'd4, 32'd8};
        clear_prog();
        prog[0] = ej(3, 16);
        prog[1] = ei(8, 0, 8, 8);
        prog[2] = 32'hC;
        prog[16] = ei(8, 0, 9, 9);
        prog[17] = er(31, 0, 0, 0, 8);
        run_prog();
        checks++;
        if (!done) begin errors++; $display("FAIL jal_timeout got done=0 want 1"); end
        checks++;
        if (dut.u11.regfile[31] !== 32'd4) begin errors++; $display("FAIL jal_r31 got %h want %h", dut.u11.regfile[31], 32'd4); end
        checks++;
        if (dut.u11.regfile[9] !== 32'd9) begin errors++; $display("FAIL jal_r9 got %0d want 9", dut.u11.regfile[9]); end
        checks++;
        if (dut.u11.regfile[8] !== 32'd8) begin errors++; $display("FAIL jr_r8 got %0d want 8", dut.u11.regfile[8]); end
        checks++;
        if (ret_pcs.size() != 5) begin errors++; $display("FAIL jal_retire_count got %0d want 5", ret_pcs.size()); end
        for (int i = 0; i < 5; i++) begin
            got = (ret_pcs.size() > i) ? ret_pcs[i] : 32'hFFFFFFFF;
            checks++;
            if (got !== exp_pc[i]) begin errors++; $display("FAIL jal_pc_wb%0d got %h want %h", i, got, exp_pc[i]); end
        end
    endtask

    task automatic test_syscall();
        clear_prog();
        prog[0] = ei(8, 0, 2, 10);
        prog[1] = 32'hC;
        run_prog();
        checks++;
        if (!done) begin errors++; $display("FAIL sys_timeout got done=0 want 1"); end
        checks++;
        if (sys_instr !== 32'hC) begin errors++; $display("FAIL sys_instr got %h want %h", sys_instr, 32'hC); end
        checks++;
        if (dut.u11.regfile[2] !== 32'hA) begin errors++; $display("FAIL sys_r2 got %h want %h", dut.u11.regfile[2], 32'hA); end
        checks++;
        if (sys_r !== 1'b1) begin errors++; $display("FAIL sys_rtype got %b want 1", sys_r); end
        checks++;
        if (sys_rw !== 1'b0) begin errors++; $display("FAIL sys_regwrite got %b want 0", sys_rw); end
    endtask

    task automatic test_reset_midrun();
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.u_imem.mem[i] = (i == 0) ? ei(8, 0, 10, 1) : 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut.instrWireMEM !== ei(8, 0, 10, 1)) begin
            errors++; $display("FAIL mid_inflight got %h want %h", dut.instrWireMEM, ei(8, 0, 10, 1));
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (dut.PC !== 32'h0) begin errors++; $display("FAIL mid_pc got %h want 0", dut.PC); end
        checks++;
        if (dut.instrWireMEM !== 32'd0 || dut.instrWireWB !== 32'd0) begin
            errors++; $display("FAIL mid_pipe got mem=%h wb=%h want 0", dut.instrWireMEM, dut.instrWireWB);
        end
        checks++;
        if (dut.instr_retired !== 1'b0) begin errors++; $display("FAIL mid_retired got %b want 0", dut.instr_retired); end
        checks++;
        if (dut.u11.regfile[10] !== 32'd0) begin errors++; $display("FAIL mid_r10 got %0d want 0", dut.u11.regfile[10]); end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_branch();
        test_jal_jr();
        test_syscall();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
